// File: rtl/mac_seq_ctrl.sv
// Streaming multiply-accumulate sequencer around an external 32x32 multiplier.
// Optional MAC_SATURATE_EN: clamp the accumulator to all-ones instead of wrapping.
module mac_seq_ctrl #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] accumulated;
    logic             v1;
    logic             v2;
    logic [63:0]      prod_r;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             accept;

    assign accept = in_valid & in_ready;
    // Extra top bit of sum is the carry out of the accumulator.
    assign sum = {1'b0, acc} + (ACC_W+1)'(prod_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_r       <= '0;
            issued      <= '0;
            accumulated <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            prod_r      <= '0;
            acc         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            acc_out     <= '0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            v1        <= 1'b0;
            v2        <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                mul_a  <= a;
                mul_b  <= b;
                issued <= issued + CNT_W'(1);
            end
            v2 <= v1;
            if (v1) begin
                prod_r <= mul_p;
            end
            if (v2) begin
`ifdef MAC_SATURATE_EN
                acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
                acc <= sum[ACC_W-1:0];
`endif
                if (sum[ACC_W]) begin
                    overflow <= 1'b1;
                end
                accumulated <= accumulated + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            len_r       <= len;
                            issued      <= '0;
                            accumulated <= '0;
                            in_ready    <= 1'b1;
                            state       <= RUN;
                        end else begin
                            acc_out   <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept && (issued + CNT_W'(1)) == len_r) begin
                        in_ready <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (accumulated == len_r) begin
                        acc_out   <= acc;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl (ACC_W=64 to reach the carry-out case).
module tb_mac_seq_ctrl;

    localparam int ACC_W = 64;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [63:0]      mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the Vedic multiplier.
    assign mul_p = 64'(mul_a) * 64'(mul_b);

    mac_seq_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .overflow(overflow), .busy(busy)
    );

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, 96'(out_valid), 96'd1);
    endtask

    task automatic push(input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        a = x;
        b = y;
        step();
    endtask

    task automatic begin_job(input logic [CNT_W-1:0] n);
        start = 1'b1;
        len = n;
        step();
        start = 1'b0;
    endtask

    logic [63:0] big_exp;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        abort = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 96'(out_valid), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_acc_out", 96'(acc_out), 96'd0);
        rst = 1'b0;
        step();

        // Job 1: back-to-back pairs, latency check
        begin_job(8'd3);
        chk("j1_in_ready", 96'(in_ready), 96'd1);
        push(32'd12, 32'd12);
        push(32'd15, 32'd13);
        push(32'd24, 32'd2);
        in_valid = 1'b0;
        chk("j1_ready_drop", 96'(in_ready), 96'd0);
        chk("j1_t1", 96'(out_valid), 96'd0);
        step();
        chk("j1_t2", 96'(out_valid), 96'd0);
        step();
        chk("j1_t3_pre", 96'(out_valid), 96'd0);
        step();
        chk("j1_t3", 96'(out_valid), 96'd1);
        chk("j1_acc", 96'(acc_out), 96'd387);
        chk("j1_ovf", 96'(overflow), 96'd0);
        step();
        chk("j1_idle_valid", 96'(out_valid), 96'd0);
        chk("j1_idle_busy", 96'(busy), 96'd0);

        // Job 2: gap between pairs, extra in_valid during drain ignored
        begin_job(8'd2);
        push(32'd200, 32'd21);
        in_valid = 1'b0;
        step();
        chk("j2_gap1_ready", 96'(in_ready), 96'd1);
        step();
        chk("j2_gap2_ready", 96'(in_ready), 96'd1);
        push(32'd36, 32'd48);
        a = 32'd1000;
        b = 32'd1000;
        wait_out("j2_out");
        chk("j2_acc", 96'(acc_out), 96'd5928);
        in_valid = 1'b0;
        step();

        // Job 3: zero-length job with held result
        out_ready = 1'b0;
        begin_job(8'd0);
        chk("j3_valid", 96'(out_valid), 96'd1);
        chk("j3_acc", 96'(acc_out), 96'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("j3_hold_valid", 96'(out_valid), 96'd1);
            chk("j3_hold_busy", 96'(busy), 96'd1);
            chk("j3_hold_acc", 96'(acc_out), 96'd0);
        end
        out_ready = 1'b1;
        step();
        chk("j3_idle", 96'(busy), 96'd0);

        // Job 4: carry out of the accumulator
        begin_job(8'd2);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        wait_out("j4_out");
`ifdef MAC_SATURATE_EN
        big_exp = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        big_exp = 64'hFFFF_FFFC_0000_0002;
`endif
        chk("j4_acc", 96'(acc_out), 96'(big_exp));
        chk("j4_ovf", 96'(overflow), 96'd1);
        step();

        // Job 5: abort in DRAIN, then a fresh job
        begin_job(8'd4);
        push(32'd1, 32'd1);
        push(32'd2, 32'd1);
        push(32'd3, 32'd1);
        push(32'd4, 32'd1);
        in_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("j5_abort_busy", 96'(busy), 96'd0);
        chk("j5_abort_valid", 96'(out_valid), 96'd0);
        chk("j5_abort_ready", 96'(in_ready), 96'd0);
        step();
        step();
        step();
        chk("j5_quiet", 96'(out_valid), 96'd0);
        begin_job(8'd1);
        push(32'd3, 32'd5);
        in_valid = 1'b0;
        wait_out("j5b_out");
        chk("j5b_acc", 96'(acc_out), 96'd15);
        chk("j5b_ovf", 96'(overflow), 96'd0);
        step();

        // Job 6: asynchronous reset mid-RUN
        begin_job(8'd2);
        push(32'd7, 32'd9);
        in_valid = 1'b0;
        chk("j6_mul_a", 96'(mul_a), 96'd7);
        #2;
        rst = 1'b1;
        #1;
        chk("j6_rst_mul_a", 96'(mul_a), 96'd0);
        chk("j6_rst_mul_b", 96'(mul_b), 96'd0);
        chk("j6_rst_busy", 96'(busy), 96'd0);
        chk("j6_rst_ready", 96'(in_ready), 96'd0);
        #1;
        rst = 1'b0;
        step();
        begin_job(8'd1);
        push(32'd2, 32'd2);
        in_valid = 1'b0;
        wait_out("j6b_out");
        chk("j6b_acc", 96'(acc_out), 96'd4);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencing controller for the 32x32 Vedic multiplier; turns the combinational multiplier into a streaming multiply-accumulate unit.
- Accepts a vector length, then streams operand pairs over valid/ready and drives the external multiplier through registered operand ports.
- Accumulates the products and presents the sum on an output valid/ready handshake.
- Sits between the operand source and the 32-bit MAC result consumer; the multiplier stays a separate instance, wired through mul_a/mul_b/mul_p.

Parameters:
- ACC_W, 72, accumulator width in bits; legal range 64 to 96; products are zero-extended to this width.
- CNT_W, 8, width of the length and element counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- start  in  1  begins a job; sampled only in IDLE.
- len  in  CNT_W  number of operand pairs in the job; latched on start.
- abort  in  1  synchronous abort, returns the block to IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  32  operand A.
- b  in  32  operand B.
- mul_a  out  32  registered operand to the multiplier.
- mul_b  out  32  registered operand to the multiplier.
- mul_p  in  64  combinational product returned from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- acc_out  out  ACC_W  accumulated result.
- overflow  out  1  sticky flag: the accumulator carried out of ACC_W during the job.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs, counters, the accumulator and the pipeline valid bits (v1, v2) go to 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start with len!=0: latch len, clear the accumulator and overflow, clear both counters, go to RUN.
  - start with len==0: clear the accumulator and overflow, go to DONE. out_valid rises on the next cycle with acc_out=0.
- RUN:
  - in_ready=1 while issued<len.
  - On in_valid&in_ready: mul_a<=a, mul_b<=b, v1<=1, issued+1.
  - When the handshake makes issued==len, move to DRAIN; in_ready drops on the following cycle.
- Pipeline, operating in both RUN and DRAIN:
  - Stage 1: mul_a/mul_b registered, v1 set.
  - Stage 2: prod_r<=mul_p when v1; v2<=v1.
  - Stage 3: acc<=acc+zero-extended prod_r when v2; accumulated+1.
  - overflow is set when the addition carries out of bit ACC_W-1. The accumulator wraps modulo 2^ACC_W.
  - One pair can be accepted per cycle, with no bubbles.
- Latency: the last pair is accepted at edge T; out_valid is high after edge T+3.
- DRAIN:
  - in_ready=0.
  - When accumulated reaches len: acc_out<=acc, out_valid<=1, go to DONE.
- DONE:
  - out_valid and acc_out stay stable until out_ready.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.
  - busy stays 1 until that handshake completes.
- start is ignored outside IDLE. len changes after the latch have no effect.
- abort in any state: return to IDLE next edge; clear v1, v2, out_valid and in_ready. The accumulator is left undefined-but-unused and is cleared on the next start.
  - abort and start in the same cycle in IDLE: abort wins, the block stays in IDLE.
  - abort and an in_valid handshake in the same cycle: the pair is dropped.
- mul_a/mul_b hold their last values when no pair is accepted.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: an addition that would carry out of ACC_W clamps the accumulator to all-ones. Once clamped, it stays at all-ones for the rest of the job. overflow is still set.
- Undefined: the accumulator wraps modulo 2^ACC_W and overflow is set.

Test Plan:
- len=3; pairs (12,12), (15,13), (24,2) on consecutive cycles, out_ready=1 -> acc_out=387, out_valid exactly 3 cycles after the last accept, overflow=0, then IDLE.
- len=2; pairs (200,21), (36,48) with in_valid low for 2 cycles between them -> acc_out=5928; in_ready high throughout RUN; no extra pair accepted.
- len=0 start -> out_valid the next cycle with acc_out=0; hold out_ready low 5 cycles -> out_valid and acc_out stable, busy=1; out_ready high -> IDLE.
- ACC_W=64; len=2; pairs (0xFFFFFFFF,0xFFFFFFFF) twice -> acc_out=0xFFFFFFFC00000002, overflow=1; with MAC_SATURATE_EN -> acc_out=0xFFFFFFFFFFFFFFFF, overflow=1.
- Abort in DRAIN (len=4, after the 4th accept) -> next cycle state IDLE, out_valid=0, busy=0; a new job with len=1, pair (3,5) -> acc_out=15, overflow=0.
- Assert rst mid-RUN (between edges) -> all outputs 0 immediately, with no clock edge needed; after release, a start with len=1, pair (2,2) -> acc_out=4.
